// File: rtl/tipi_serial_rx.sv
// tipi_serial_rx: synchronized serial-in, parallel-out byte receiver.
// Optional odd-parity frame bit enabled by defining TIPI_RX_PARITY_EN.
module tipi_serial_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_clk,
    input  logic       s_din,
    input  logic       s_frame,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ack,
    output logic       overrun,
    output logic       parity_err,
    output logic [3:0] bit_cnt
);

`ifdef TIPI_RX_PARITY_EN
    localparam int         SW     = 8;
    localparam logic [3:0] N_LAST = 4'd8;
`else
    localparam int         SW     = 7;
    localparam logic [3:0] N_LAST = 4'd7;
`endif

    logic [SYNC_STAGES-1:0] sclk_q, din_q, frm_q;
    logic                   sclk_prev_q;
    logic [SW-1:0]          shift_q, shift_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic                   sclk_s, din_s, frm_s;
    logic                   rise, shift_en, complete, take;
    logic [7:0]             byte_w;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign din_s  = din_q[SYNC_STAGES-1];
    assign frm_s  = frm_q[SYNC_STAGES-1];

    assign rise     = sclk_s & ~sclk_prev_q;
    assign shift_en = rise & ~frm_s;
    assign complete = shift_en & (cnt_q == N_LAST);
    assign take     = rd_ack & valid_q;

`ifdef TIPI_RX_PARITY_EN
    // The ninth bit is parity; the byte is already fully shifted in.
    assign byte_w = shift_q;
`else
    assign byte_w = {shift_q, din_s};
`endif

    // Synchronizers and s_clk edge-detect flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q      <= '0;
            din_q       <= '0;
            frm_q       <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], s_clk};
            din_q       <= {din_q[SYNC_STAGES-2:0], s_din};
            frm_q       <= {frm_q[SYNC_STAGES-2:0], s_frame};
            sclk_prev_q <= sclk_s;
        end
    end

    // Next-state for shifter, bit counter and read-side handshake.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (frm_s) begin
            shift_d = '0;
            cnt_d   = 4'd0;
        end else if (shift_en) begin
            shift_d = {shift_q[SW-2:0], din_s};
            cnt_d   = complete ? 4'd0 : cnt_q + 4'd1;
        end
        if (complete) begin
            if (!valid_q || rd_ack) begin
                data_d  = byte_w;
                valid_d = 1'b1;
                if (take) ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (take) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Datapath and handshake state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= 4'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef TIPI_RX_PARITY_EN
    logic perr_q;

    // Odd parity over 8 data bits plus parity bit, captured on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else if (complete && (!valid_q || rd_ack)) begin
            perr_q <= ~(^shift_q ^ din_s);
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign overrun  = ovr_q;
    assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_tipi_serial_rx.sv
// tb_tipi_serial_rx: directed checks of tipi_serial_rx.
// Define TIPI_RX_PARITY_EN to exercise the parity frame.
module tb_tipi_serial_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_clk = 1'b0;
    logic       s_din = 1'b0;
    logic       s_frame = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       overrun;
    logic       parity_err;
    logic [3:0] bit_cnt;

    int checks = 0;
    int errors = 0;

`ifdef TIPI_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    tipi_serial_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_clk     (s_clk),
        .s_din     (s_din),
        .s_frame   (s_frame),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ack    (rd_ack),
        .overrun   (overrun),
        .parity_err(parity_err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One serial bit: 4 clk high, 4 clk low. On the last bit of a
    // frame optionally check latency and/or ack on the completion edge.
    task automatic send_bit(input logic b, input bit last,
                            input bit ack, input bit lat);
        s_din = b;
        @(negedge clk);
        s_clk = 1'b1;
        if (last) begin
            idle(2);
            if (lat) chk("lat_pre", {7'd0, rd_valid}, 8'h00);
            if (ack) rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
            if (lat) chk("lat_post", {7'd0, rd_valid}, 8'h01);
            @(negedge clk);
        end else begin
            idle(4);
        end
        s_clk = 1'b0;
        idle(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p,
                             input bit ack, input bit lat);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i], (i == 0) && !PAR, ack, lat);
        if (PAR) send_bit(p, 1'b1, ack, lat);
    endtask

    task automatic do_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        idle(2);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_valid", {7'd0, rd_valid}, 8'h00);
        chk("rst_ovr", {7'd0, overrun}, 8'h00);
        chk("rst_perr", {7'd0, parity_err}, 8'h00);
        chk("rst_cnt", {4'd0, bit_cnt}, 8'h00);
        reset_n = 1'b1;
        idle(2);

        // Fill output, then reset in the middle of a frame.
        send_byte(8'h11, ~^8'h11, 1'b0, 1'b0);
        chk("pre_data", rd_data, 8'h11);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_cnt", {4'd0, bit_cnt}, 8'h03);
        reset_n = 1'b0;
        #1;
        chk("mr_data", rd_data, 8'h00);
        chk("mr_valid", {7'd0, rd_valid}, 8'h00);
        chk("mr_cnt", {4'd0, bit_cnt}, 8'h00);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // 0xA5 with latency check on the final bit.
        send_byte(8'hA5, ~^8'hA5, 1'b0, 1'b1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_valid", {7'd0, rd_valid}, 8'h01);
        chk("a5_cnt", {4'd0, bit_cnt}, 8'h00);
        do_ack();
        chk("a5_ack", {7'd0, rd_valid}, 8'h00);

        // Partial 0xFF bits, frame pulse, then 0x12.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        chk("part_cnt", {4'd0, bit_cnt}, 8'h05);
        s_frame = 1'b1;
        idle(4);
        chk("frm_cnt", {4'd0, bit_cnt}, 8'h00);
        s_frame = 1'b0;
        idle(4);
        send_byte(8'h12, ~^8'h12, 1'b0, 1'b0);
        chk("f12_data", rd_data, 8'h12);
        chk("f12_valid", {7'd0, rd_valid}, 8'h01);

        // Frame held across s_clk toggles.
        s_frame = 1'b1;
        idle(3);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_cnt", {4'd0, bit_cnt}, 8'h00);
        chk("hold_valid", {7'd0, rd_valid}, 8'h01);
        chk("hold_data", rd_data, 8'h12);
        s_frame = 1'b0;
        idle(4);
        do_ack();

        // Overrun: second byte dropped.
        send_byte(8'h3C, ~^8'h3C, 1'b0, 1'b0);
        send_byte(8'h81, ~^8'h81, 1'b0, 1'b0);
        chk("ovr_data", rd_data, 8'h3C);
        chk("ovr_flag", {7'd0, overrun}, 8'h01);
        chk("ovr_valid", {7'd0, rd_valid}, 8'h01);
        do_ack();
        chk("ovr_ack_v", {7'd0, rd_valid}, 8'h00);
        chk("ovr_ack_o", {7'd0, overrun}, 8'h00);

        // Ack coincident with completion clears overrun, loads 0x7E.
        send_byte(8'h55, ~^8'h55, 1'b0, 1'b0);
        send_byte(8'h66, ~^8'h66, 1'b0, 1'b0);
        chk("pre7e_ovr", {7'd0, overrun}, 8'h01);
        send_byte(8'h7E, ~^8'h7E, 1'b1, 1'b0);
        chk("7e_data", rd_data, 8'h7E);
        chk("7e_valid", {7'd0, rd_valid}, 8'h01);
        chk("7e_ovr", {7'd0, overrun}, 8'h00);
        do_ack();

`ifdef TIPI_RX_PARITY_EN
        send_byte(8'h01, 1'b0, 1'b0, 1'b0);
        chk("p0_data", rd_data, 8'h01);
        chk("p0_perr", {7'd0, parity_err}, 8'h00);
        do_ack();
        send_byte(8'h01, 1'b1, 1'b0, 1'b0);
        chk("p1_data", rd_data, 8'h01);
        chk("p1_perr", {7'd0, parity_err}, 8'h01);
        do_ack();
`else
        chk("noparity", {7'd0, parity_err}, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tipi_serial_rx.md
# tipi_serial_rx

Serial-in, parallel-out receive stage for the CPLD data path. It consumes the MSB-first bit stream that the Pi-side shifter drives, and presents completed bytes to the register file through a valid/ack handshake. It sits directly downstream of the parallel-load shift-out stage, mirroring it for the Pi→TI direction. The asynchronous serial clock and frame inputs are synchronized into the system clock domain before use.

## Interface
- SYNC_STAGES, 2, synchronizer depth for s_clk/s_din/s_frame; legal values 2 or 3.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_clk  in  1  serial bit clock from Pi, asynchronous; data sampled on its rising edge.
- s_din  in  1  serial data, MSB first.
- s_frame  in  1  frame sync, active high, asynchronous; clears partial byte.
- rd_data  out  8  last completed byte.
- rd_valid  out  1  rd_data holds an unconsumed byte.
- rd_ack  in  1  consumer takes rd_data this cycle; ignored when rd_valid=0.
- overrun  out  1  sticky: a byte completed while rd_valid=1 and no ack.
- parity_err  out  1  parity result of last accepted byte; constant 0 without TIPI_RX_PARITY_EN.
- bit_cnt  out  4  debug: bits received in current frame.

## Operation
- Reset (reset_n=0, asynchronous): all synchronizer flops, shift register, bit_cnt, rd_data=8'h00, rd_valid=0, overrun=0, parity_err=0.
- s_clk, s_din, s_frame each pass through SYNC_STAGES flops; s_clk gets one extra flop for edge detect. rise = s_clk_sync & ~s_clk_prev.
- On rise with frame inactive: shift = {shift[6:0], din_sync}; bit_cnt++.
- Frame length N = 8 (9 with parity). On rise that makes bit_cnt reach N: completion; bit_cnt returns to 0 in the same cycle.
- Completion, rd_valid=0 or rd_ack=1 same cycle: rd_data ← assembled byte, rd_valid=1, parity_err updated.
- Completion, rd_valid=1 and rd_ack=0: byte dropped; rd_data, parity_err unchanged; overrun=1.
- rd_ack with rd_valid=1 and no completion: rd_valid=0, overrun=0.
- rd_ack with rd_valid=1 and completion: new byte loaded, rd_valid stays 1, overrun=0.
- s_frame_sync=1: bit_cnt=0, shift=0, any coincident rise ignored; rd_data/rd_valid/overrun untouched. Frame has priority over rise.
- bit_cnt never exceeds N−1 when observed between completions.

## Timing
- Latency: final s_clk rise at pin → rd_valid high after SYNC_STAGES+1 clk edges.
- s_clk high and low time each ≥ SYNC_STAGES+1 clk periods; faster toggles are undefined.
- s_din stable from 1 clk period before to SYNC_STAGES+1 clk periods after s_clk rise.
- s_frame pulse ≥ SYNC_STAGES+1 clk periods; must deassert before the first bit's s_clk rise.
- rd_ack takes effect at the same clk edge; rd_valid may re-assert the next cycle.
- rd_data stable while rd_valid=1 until ack.

## Configuration
- TIPI_RX_PARITY_EN defined: frame is 9 bits, 8 data MSB first then one parity bit; odd parity over all 9 bits. On accepted byte parity_err ← (XOR of 9 bits == 0). The parity bit is not stored in rd_data.
- Undefined: frame is 8 bits, parity_err tied 0, no parity logic.

## Test plan
- Reset mid-frame after 3 bits → all outputs 0, bit_cnt=0; next 8 bits 0xA5 → rd_data=8'hA5, rd_valid=1 SYNC_STAGES+1 clks after last rise.
- Send 0x3C, no ack, send 0x81 → rd_data=8'h3C, overrun=1; ack → rd_valid=0, overrun=0.
- rd_ack asserted on exact completion cycle of second byte 0x7E → rd_data=8'h7E, rd_valid=1, overrun=0.
- 5 bits of 0xFF, s_frame pulse, then 0x12 → rd_data=8'h12, no partial-bit contamination.
- s_frame held high while s_clk toggles 4 times → bit_cnt stays 0, rd_valid unchanged.
- With TIPI_RX_PARITY_EN: 0x01 + parity 0 → parity_err=0; 0x01 + parity 1 → parity_err=1, rd_data=8'h01 both times.
